store_monitor: RTL and testbench

- Sits directly downstream of the CPU `top` data-memory bus and consumes its store stream (mem_write, data_adr, write_data) every cycle.
- Classifies stores against a pass/scratch address map and drives a terminal run status: RUNNING, PASS, FAIL or TIMEOUT.
- Buffers every accepted store in a trace FIFO that a consumer drains over a valid/ready port.
- Synthesizable replacement for ad-hoc bench checking; usable in simulation and on FPGA.

---
 rtl/store_monitor_pkg.sv | 16 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/store_monitor.sv | 82 ++++++++
 tb/tb_store_monitor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/store_monitor_pkg.sv
// Shared types for the store monitor: run status encoding and trace entry layout.
package store_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUNNING = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Pointers carry one extra wrap bit so that full and empty
// fall out of a plain pointer compare. A push is accepted when full only if
// a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so the outputs are clean after reset.
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/store_monitor.sv
// Watches the CPU store stream, classifies stores against the pass/scratch
// map, tracks a run timeout and records every store taken while running.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] PASS_ADDR    = 32'd100,
  parameter logic [31:0] PASS_DATA    = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR = 32'd96,
  parameter int          TIMEOUT      = 1000,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_write,
  input  logic [31:0]      data_adr,
  input  logic [31:0]      write_data,
  input  logic             trace_ready,
  output logic             trace_valid,
  output logic [31:0]      trace_adr,
  output logic [31:0]      trace_data,
  output logic             trace_overflow,
  output logic [1:0]       status,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);
  status_e      st, st_nxt;
  logic         running, push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] cnt_nxt;
  trace_entry_t wr_e, rd_e;

  assign running     = (st == ST_RUNNING);
  assign push        = mem_write && running;
  assign pop         = trace_valid && trace_ready;
  assign cnt_nxt     = cycle_count + 1'b1;
  assign wr_e        = '{adr: data_adr, data: write_data};
  assign trace_valid = !fifo_empty;
  assign trace_adr   = rd_e.adr;
  assign trace_data  = rd_e.data;
  assign status      = st;
  assign done        = !running;

  // Next status while running: timeout first, a classifying store overrides it.
  always_comb begin
    st_nxt = ST_RUNNING;
    if (cnt_nxt == CNT_W'(TIMEOUT)) st_nxt = ST_TIMEOUT;
    if (mem_write) begin
      if (data_adr == PASS_ADDR && write_data == PASS_DATA) st_nxt = ST_PASS;
      else if (data_adr != SCRATCH_ADDR)                    st_nxt = ST_FAIL;
    end
  end

  // Status FSM, run counter and sticky overflow; terminal states hold until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      st             <= ST_RUNNING;
      cycle_count    <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (running) begin
        st          <= st_nxt;
        cycle_count <= cnt_nxt;
      end
      if (push && fifo_full && !pop) trace_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(trace_entry_t)),
    .DEPTH (DEPTH)
  ) u_trace (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_e),
    .pop   (pop),
    .rdata (rd_e),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_store_monitor.sv
// Directed plus randomized bench for store_monitor, checked every cycle
// against a queue-based reference model of the run status and trace.
module tb_store_monitor;
  localparam int TO  = 16;
  localparam int DEP = 8;

  logic        clk = 1'b0;
  logic        reset, mem_write, trace_ready;
  logic [31:0] data_adr, write_data;
  logic        trace_valid, trace_overflow, done;
  logic [31:0] trace_adr, trace_data, cycle_count;
  logic [1:0]  status;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          m_st;   // 0 run, 1 pass, 2 fail, 3 timeout
  int unsigned m_cnt;
  bit          m_ovf;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  store_monitor #(
    .DEPTH (DEP), .PASS_ADDR (32'd100), .PASS_DATA (32'd25),
    .SCRATCH_ADDR (32'd96), .TIMEOUT (TO), .CNT_W (32)
  ) dut (
    .clk (clk), .reset (reset), .mem_write (mem_write),
    .data_adr (data_adr), .write_data (write_data),
    .trace_ready (trace_ready), .trace_valid (trace_valid),
    .trace_adr (trace_adr), .trace_data (trace_data),
    .trace_overflow (trace_overflow), .status (status),
    .done (done), .cycle_count (cycle_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit mw, input logic [31:0] a,
                       input logic [31:0] d, input bit tr);
    bit popped;
    if (r) begin
      m_st = 0; m_cnt = 0; m_ovf = 0; q.delete();
      return;
    end
    popped = tr && (q.size() > 0);
    if (popped) void'(q.pop_front());
    if (m_st == 0) begin
      m_cnt++;
      if (m_cnt == TO) m_st = 3;
      if (mw) begin
        if (a == 100 && d == 25) m_st = 1;
        else if (a != 96)        m_st = 2;
        if (q.size() < DEP) q.push_back({a, d});
        else                m_ovf = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit mw, input logic [31:0] a,
                      input logic [31:0] d, input bit tr);
    reset = r; mem_write = mw; data_adr = a; write_data = d; trace_ready = tr;
    @(posedge clk);
    model(r, mw, a, d, tr);
    #1;
    check("status",      64'(status),         64'(m_st));
    check("done",        64'(done),           64'(m_st != 0));
    check("cycle_count", 64'(cycle_count),    64'(m_cnt));
    check("valid",       64'(trace_valid),    64'(q.size() > 0));
    check("overflow",    64'(trace_overflow), 64'(m_ovf));
    check("head_adr",    64'(trace_adr),      q.size() > 0 ? 64'(q[0][63:32]) : 64'd0);
    check("head_data",   64'(trace_data),     q.size() > 0 ? 64'(q[0][31:0])  : 64'd0);
  endtask

  task automatic idle(input bit tr);
    step(1'b0, 1'b0, 32'd0, 32'd0, tr);
  endtask

  task automatic rst;
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    m_st = 0; m_cnt = 0; m_ovf = 0;
    reset = 1; mem_write = 0; data_adr = 0; write_data = 0; trace_ready = 0;

    // reset held three cycles, then five idle cycles
    rst; rst; rst;
    check("rst_status", 64'(status), 64'd0);
    check("rst_count",  64'(cycle_count), 64'd0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    check("count5", 64'(cycle_count), 64'd5);

    // scratch then pass; later store is not traced
    rst;
    step(0, 1, 96, 7, 1);
    check("head96", 64'({trace_adr, trace_data}), {32'd96, 32'd7});
    step(0, 1, 100, 25, 1);
    check("pass_status", 64'(status), 64'd1);
    check("pass_done",   64'(done), 64'd1);
    check("head100", 64'({trace_adr, trace_data}), {32'd100, 32'd25});
    step(0, 1, 96, 1, 1);
    check("not_traced", 64'(trace_valid), 64'd0);
    idle(1);

    // wrong pass data, then a non-map address
    rst;
    step(0, 1, 100, 24, 0);
    check("fail_a", 64'(status), 64'd2);
    check("fail_a_tr", 64'({trace_adr, trace_data}), {32'd100, 32'd24});
    rst;
    step(0, 1, 104, 25, 0);
    check("fail_b", 64'(status), 64'd2);
    check("fail_b_tr", 64'({trace_adr, trace_data}), {32'd104, 32'd25});

    // timeout with no stores, counter freezes
    rst;
    for (int i = 0; i < TO; i++) idle(1'b0);
    check("timeout", 64'(status), 64'd3);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check("to_frozen", 64'(cycle_count), 64'd16);
    // pass store on the timeout edge wins
    rst;
    for (int i = 0; i < TO - 1; i++) idle(1'b0);
    step(0, 1, 100, 25, 0);
    check("pass_on_to", 64'(status), 64'd1);
    check("cnt_on_to",  64'(cycle_count), 64'd16);

    // overflow: nine stores into eight entries, then drain
    rst;
    for (int i = 1; i <= 9; i++) step(0, 1, 96, 32'(i), 0);
    check("ovf_set", 64'(trace_overflow), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      check("drain", 64'(trace_data), 64'(i));
      idle(1);
    end
    check("drained", 64'(trace_valid), 64'd0);

    // push and pop together at full: nothing dropped
    rst;
    for (int i = 1; i <= 8; i++) step(0, 1, 96, 32'(i), 0);
    step(0, 1, 96, 9, 1);
    check("pp_noovf", 64'(trace_overflow), 64'd0);
    check("pp_head",  64'(trace_data), 64'd2);

    // reset mid-drain
    rst;
    for (int i = 1; i <= 4; i++) step(0, 1, 96, 32'(i), 0);
    step(1, 0, 0, 0, 1);
    check("mid_valid", 64'(trace_valid), 64'd0);
    check("mid_stat",  64'(status), 64'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit r, mw, tr;
      logic [31:0] a, d;
      int k;
      r  = ($urandom % 25) == 0;
      mw = ($urandom % 3) != 0;
      k  = $urandom % 10;
      a  = (k < 7) ? 32'd96 : (k == 7) ? 32'd100 : (k == 8) ? 32'd104 : $urandom;
      d  = ($urandom % 2) ? 32'd25 : 32'($urandom % 64);
      tr = ($urandom % 3) == 0;
      step(r, mw, a, d, tr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
